// File: rtl/pipelined_adder.sv
// pipelined_adder: segmented-carry pipelined add/subtract with valid/ready backpressure
//   clk, rst                     : clock, synchronous active-high reset
//   in_valid/in_ready            : input handshake (in_ready = !out_valid || out_ready)
//   operand_a, operand_b, sub    : operands, sub=1 selects a-b
//   out_valid/out_ready          : output handshake
//   adder_data, carry_out, overflow : result and flags
//   PIPELINED_ADDER_FLAGS_EN     : when defined, drive carry_out/overflow; otherwise tied to 0
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] adder_data,
    output logic             carry_out,
    output logic             overflow
);
    localparam int SEG  = WIDTH / STAGES;
    localparam int SEG1 = SEG + 1;
    localparam int L    = STAGES - 1;
    logic             v_q [STAGES];
    logic             v_d [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic             c_q [STAGES];
    logic             c_d [STAGES];
    logic             ci  [STAGES];
    logic             adv;
    assign adv        = !v_q[L] || out_ready;
    assign in_ready   = adv;
    assign out_valid  = v_q[L];
    assign adder_data = s_q[L];
    // Each stage forwards the operands and partial sum of the previous one and fills in its own segment.
    always_comb begin
        v_d[0] = in_valid;
        a_d[0] = operand_a;
        b_d[0] = sub ? ~operand_b : operand_b;
        s_d[0] = '0;
        ci[0]  = sub;
        for (int k = 1; k < STAGES; k++) begin
            v_d[k] = v_q[k-1];
            a_d[k] = a_q[k-1];
            b_d[k] = b_q[k-1];
            s_d[k] = s_q[k-1];
            ci[k]  = c_q[k-1];
        end
        for (int k = 0; k < STAGES; k++)
            {c_d[k], s_d[k][k*SEG +: SEG]} = {1'b0, a_d[k][k*SEG +: SEG]}
                                           + {1'b0, b_d[k][k*SEG +: SEG]} + SEG1'(ci[k]);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_d[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
            end
        end
    end
`ifdef PIPELINED_ADDER_FLAGS_EN
    assign carry_out = c_q[L];
    assign overflow  = (a_q[L][WIDTH-1] == b_q[L][WIDTH-1]) && (s_q[L][WIDTH-1] != a_q[L][WIDTH-1]);
`else
    assign carry_out = 1'b0;
    assign overflow  = 1'b0;
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: vector table plus scoreboarded random streams for pipelined_adder
module tb_pipelined_adder;
    parameter int S = 4;
    localparam int W = 32;
    localparam longint MAXS = (longint'(1) <<< (W - 1)) - 1;
    localparam longint MINS = -(longint'(1) <<< (W - 1));
`ifdef PIPELINED_ADDER_FLAGS_EN
    localparam bit FEN = 1'b1;
`else
    localparam bit FEN = 1'b0;
`endif
    typedef struct {
        logic [W-1:0] d;
        logic         c;
        logic         o;
    } exp_t;
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        exp_t         e;
    } vec_t;
    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, sub = 1'b0;
    logic out_valid, out_ready = 1'b1, carry_out, overflow;
    logic [W-1:0] operand_a = '0, operand_b = '0, adder_data;
    int checks = 0, errors = 0, cyc = 0, prev_cyc = 0;
    bit stall_en = 0, thru = 0, have_prev = 0, hold_v = 0;
    exp_t cur_exp, hold, q[$];
    vec_t tab[10];
    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .operand_a(operand_a), .operand_b(operand_b), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .adder_data(adder_data),
        .carry_out(carry_out), .overflow(overflow)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, act, exp);
        end
    endtask
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t e;
        logic [W:0] u;
        longint r;
        u = s ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
        r = s ? longint'($signed(a)) - longint'($signed(b)) : longint'($signed(a)) + longint'($signed(b));
        e.d = u[W-1:0];
        e.c = FEN & (s ? (a >= b) : u[W]);
        e.o = FEN & ((r > MAXS) || (r < MINS));
        return e;
    endfunction
    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                input logic [W-1:0] d, input logic c, input logic o);
        vec_t v;
        v.a = a; v.b = b; v.s = s;
        v.e.d = d; v.e.c = c & FEN; v.e.o = o & FEN;
        return v;
    endfunction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            chk("in_ready_rule", in_ready, !out_valid || out_ready);
            if (rst) begin
                q.delete();
                hold_v = 0;
            end else begin
                if (hold_v) begin
                    chk("stall_valid", out_valid, 1);
                    chk("stall_data", adder_data, hold.d);
                    chk("stall_carry", carry_out, hold.c);
                    chk("stall_ovf", overflow, hold.o);
                end
                hold_v = out_valid && !out_ready;
                hold.d = adder_data; hold.c = carry_out; hold.o = overflow;
                if (out_valid && out_ready) begin
                    if (q.size() == 0) chk("unexpected_out", out_valid, 0);
                    else begin
                        e = q.pop_front();
                        chk("data", adder_data, e.d);
                        chk("carry", carry_out, e.c);
                        chk("ovf", overflow, e.o);
                        if (thru && have_prev) chk("throughput", cyc, prev_cyc + 1);
                        prev_cyc = cyc;
                        have_prev = 1;
                    end
                end
                if (in_valid && in_ready) q.push_back(cur_exp);
            end
        end
    end
    initial forever begin
        @(posedge clk);
        #1;
        out_ready = stall_en ? ($urandom_range(0, 9) >= 3) : 1'b1;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input exp_t e);
        int n = 0;
        bit t = 0;
        operand_a = a; operand_b = b; sub = s; cur_exp = e; in_valid = 1'b1;
        do begin
            @(negedge clk);
            t = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!t && n < 1000);
        if (!t) chk("send_timeout", in_ready, 1);
        in_valid = 1'b0;
    endtask
    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask
    task automatic latency(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int n = 0;
        operand_a = a; operand_b = b; sub = s; cur_exp = model(a, b, s); in_valid = 1'b1;
        do begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            n++;
        end while (!out_valid && n < 50);
        chk("latency", n, S);
    endtask
    initial begin
        logic [W-1:0] a, b;
        logic s;
        tab[0] = mk(32'h0000_0013, 32'h0000_0004, 0, 32'h0000_0017, 0, 0);
        tab[1] = mk(32'hFFFF_FFFF, 32'h0000_0001, 0, 32'h0000_0000, 1, 0);
        tab[2] = mk(32'h7FFF_FFFF, 32'h0000_0001, 0, 32'h8000_0000, 0, 1);
        tab[3] = mk(32'h8000_0000, 32'h0000_0001, 1, 32'h7FFF_FFFF, 1, 1);
        tab[4] = mk(32'h0000_0005, 32'h0000_0007, 1, 32'hFFFF_FFFE, 0, 0);
        tab[5] = mk(32'h0000_0000, 32'h0000_0000, 1, 32'h0000_0000, 1, 0);
        tab[6] = mk(32'h8000_0000, 32'h8000_0000, 0, 32'h0000_0000, 1, 1);
        tab[7] = mk(32'h0000_0001, 32'h8000_0000, 1, 32'h8000_0001, 0, 1);
        tab[8] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0000_0000, 1, 0);
        tab[9] = mk(32'h1234_5678, 32'h0FED_CBA9, 0, 32'h2222_2221, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data", adder_data, 0);
        chk("rst_carry", carry_out, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        latency(32'd19, 32'd4, 1'b0);
        drain();
        for (int i = 0; i < 10; i++) send(tab[i].a, tab[i].b, tab[i].s, tab[i].e);
        drain();
        thru = 1;
        have_prev = 0;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom(); b = $urandom(); s = $urandom_range(0, 1);
            send(a, b, s, model(a, b, s));
        end
        drain();
        thru = 0;
        stall_en = 1;
        for (int i = 0; i < 300; i++) begin
            a = $urandom(); b = $urandom(); s = $urandom_range(0, 1);
            send(a, b, s, model(a, b, s));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        drain();
        stall_en = 0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send(32'h100 + i, 32'h5, 1'b0, model(32'h100 + i, 32'h5, 1'b0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        @(posedge clk);
        #1;
        latency(32'hDEAD_BEEF, 32'h1111_1111, 1'b1);
        drain();
        repeat (20) @(posedge clk);
        #1;
        chk("final_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
